// File: rtl/mips_pkg.sv
// Shared definitions for the instruction cache: geometry, PC field extraction
// helpers and the refill controller state type.
package mips_pkg;

    localparam int SETS       = 64;
    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = $clog2(SETS);
    localparam int OFF_W      = $clog2(LINE_WORDS);
    localparam int TAG_W      = 32 - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } icache_state_t;

    // Word offset of a byte address within its line.
    function automatic logic [OFF_W-1:0] pcOff(input logic [31:0] pc);
        return pc[2 +: OFF_W];
    endfunction

    // Set index of a byte address.
    function automatic logic [IDX_W-1:0] pcIdx(input logic [31:0] pc);
        return pc[2+OFF_W +: IDX_W];
    endfunction

    // Tag bits of a byte address.
    function automatic logic [TAG_W-1:0] pcTag(input logic [31:0] pc);
        return pc[31 -: TAG_W];
    endfunction

    // Line-aligned byte address (offset and byte bits cleared).
    function automatic logic [31:0] lineBase(input logic [31:0] pc);
        return {pc[31:2+OFF_W], {(2+OFF_W){1'b0}}};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped storage for the instruction cache: valid bits, tags and line
// data, with two asynchronous read ports and one word-wide write port.
module icache_array
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idxA,
    input  logic [OFF_W-1:0] offA,
    output logic             validA,
    output logic [TAG_W-1:0] tagA,
    output logic [31:0]      wordA,
    input  logic [IDX_W-1:0] idxB,
    input  logic [OFF_W-1:0] offB,
    output logic             validB,
    output logic [TAG_W-1:0] tagB,
    output logic [31:0]      wordB,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [OFF_W-1:0] wrOff,
    input  logic [31:0]      wrData,
    input  logic             wrLast,
    input  logic [TAG_W-1:0] wrTag
);

    logic [SETS-1:0]  validBits;
    logic [TAG_W-1:0] tagMem  [SETS];
    logic [31:0]      dataMem [SETS][LINE_WORDS];

    assign validA = validBits[idxA];
    assign tagA   = tagMem[idxA];
    assign wordA  = dataMem[idxA][offA];
    assign validB = validBits[idxB];
    assign tagB   = tagMem[idxB];
    assign wordB  = dataMem[idxB][offB];

    // Valid bits: cleared by reset; a line under refill drops valid on its first
    // word and only becomes valid again with the last word, so it is never
    // visible half-written.
    always_ff @(posedge clk) begin
        if (!rst) begin
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrIdx] <= wrLast;
        end
    end

    // Data words are written one beat at a time; the tag lands with the last beat.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            dataMem[wrIdx][wrOff] <= wrData;
            if (wrLast) begin
                tagMem[wrIdx] <= wrTag;
            end
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Dual-word instruction cache front end: looks up pcF and pcF+4 every cycle,
// and on a miss refills the missing line(s) from main memory one at a time.
module icache_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    output logic [31:0] instrF1,
    output logic [31:0] instrF2,
    output logic        hitF,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    icache_state_t    state, stateNext;
    logic [OFF_W-1:0] beatCnt, beatCntNext;
    logic [31:0]      refillAddr, refillAddrNext;

    logic [31:0]      pcNext;
    logic [IDX_W-1:0] idxA, idxB;
    logic [OFF_W-1:0] offA, offB;
    logic             validA, validB;
    logic [TAG_W-1:0] tagA, tagB;
    logic [31:0]      wordA, wordB;
    logic             hitA, hitB;
    logic             wrEn, wrLast;

    assign pcNext   = pcF + 32'd4;
    assign idxA     = pcIdx(pcF);
    assign offA     = pcOff(pcF);
    assign idxB     = pcIdx(pcNext);
    assign offB     = pcOff(pcNext);
    assign mem_addr = refillAddr;

    icache_array uArray (
        .clk    (clk),
        .rst    (rst),
        .idxA   (idxA),
        .offA   (offA),
        .validA (validA),
        .tagA   (tagA),
        .wordA  (wordA),
        .idxB   (idxB),
        .offB   (offB),
        .validB (validB),
        .tagB   (tagB),
        .wordB  (wordB),
        .wrEn   (wrEn),
        .wrIdx  (pcIdx(refillAddr)),
        .wrOff  (beatCnt),
        .wrData (mem_rdata),
        .wrLast (wrLast),
        .wrTag  (pcTag(refillAddr))
    );

    // Lookup: both words must be resident, and nothing is returned while a
    // refill is in flight or reset is held, so the fetch stage stalls instead.
    always_comb begin
        hitA    = validA && (tagA == pcTag(pcF));
        hitB    = validB && (tagB == pcTag(pcNext));
        hitF    = rst && (state == IDLE) && hitA && hitB;
        instrF1 = hitF ? wordA : 32'h0;
        instrF2 = hitF ? wordB : 32'h0;
    end

    // Refill sequencing: pick the first missing line (pcF before pcF+4), hold
    // the request until memory takes it, then count beats into the line.
    always_comb begin
        stateNext      = state;
        beatCntNext    = beatCnt;
        refillAddrNext = refillAddr;
        mem_req        = 1'b0;
        wrEn           = 1'b0;
        wrLast         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!hitA) begin
                    refillAddrNext = lineBase(pcF);
                    stateNext      = REQ;
                end else if (!hitB) begin
                    refillAddrNext = lineBase(pcNext);
                    stateNext      = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    beatCntNext = '0;
                    stateNext   = FILL;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    wrEn        = 1'b1;
                    beatCntNext = beatCnt + 1'b1;
                    if (beatCnt == OFF_W'(LINE_WORDS - 1)) begin
                        wrLast    = 1'b1;
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Controller registers; reset abandons any refill in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            beatCnt    <= '0;
            refillAddr <= '0;
        end else begin
            state      <= stateNext;
            beatCnt    <= beatCntNext;
            refillAddr <= refillAddrNext;
        end
    end

endmodule
